seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the 8-digit multiplexed seven-segment scan driver. Samples the scanned digit-select and segment buses, rejects transition glitches, decodes each segment pattern back to its hex nibble, and reassembles the full 32-bit display word. Used for loopback self-check of the display path on the board and as a bench monitor.

## Interface
- STABLE_CYC, 4: consecutive identical samples required before a digit is accepted (≥2).
- TIMEOUT_CYC, 100000: cycles without an accepted digit before the scan is declared lost.
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Sel  input  8  digit select, active-high one-hot; bit i = digit i; digit 7 carries word bits [31:28], digit 0 bits [3:0].
- Seg  input  8  segment bus, active-low, bit order {dp,g,f,e,d,c,b,a}; dp ignored.
- Data_Out  output  32  last completed word.
- Data_Valid  output  1  one-cycle pulse when Data_Out updates.
- Frame_Err  output  1  sticky until next Data_Valid: completed frame held an undecodable digit.
- Scan_Lost  output  1  high while timeout is active; clears on next accepted digit.

## Operation
- Sel and Seg registered once (s_sel, s_seg) every cycle; all decisions use registered copies.
- Decode table, Seg[6:0] → nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. Any other pattern is invalid: stored nibble 0, digit error bit set.
- FSM, three states:
  - WAIT: s_sel not exactly one-hot (zero or multi-hot). Stable count held at 0. Go to SETTLE when s_sel is one-hot.
  - SETTLE: count increments each cycle {s_sel,s_seg} equals previous cycle; any change resets count to 1 (stay SETTLE if still one-hot, else WAIT). When count reaches STABLE_CYC: capture digit, go to CAPTURED.
  - CAPTURED: no further capture. Any change of {s_sel,s_seg}: go to SETTLE with count 1 (or WAIT if not one-hot).
- Capture: nibble and error bit written into the slot for the selected digit; digit mask bit set. Re-capture of an already-masked digit overwrites it (latest wins).
- Frame completion: when the capture makes mask 8'hFF, the next cycle loads Data_Out from the eight slots, pulses Data_Valid, sets Frame_Err = OR of the eight error bits, and clears mask and error bits.
- Timeout: idle counter resets on every capture, else increments, saturating. On reaching TIMEOUT_CYC: Scan_Lost=1, mask and error bits cleared (partial frame discarded); Data_Out retained.
- Counter widths: $clog2(STABLE_CYC+1) and $clog2(TIMEOUT_CYC+1); no wrap.

## Timing
- Reset values: Data_Out=0, Data_Valid=0, Frame_Err=0, Scan_Lost=0, mask=0, FSM=WAIT, all counters 0, s_sel=0, s_seg=8'hFF.
- Latency: input stable at Sel/Seg on cycle N → s_* on N+1 → capture on cycle N+STABLE_CYC → Data_Valid (if frame completes) on N+STABLE_CYC+1.
- Dwell shorter than STABLE_CYC cycles is never captured.
- Capture and timeout in same cycle: capture wins, idle counter reset, Scan_Lost cleared.
- Reset asserted mid-frame: all state returns to reset values on that edge; partial frame lost; no Data_Valid.
- Data_Valid never asserts on consecutive cycles (at least STABLE_CYC between captures).

## Test plan
- Scan 32'h12345678 with 1000-cycle dwell per digit, order 0..7 → single Data_Valid after digit 7 settles, Data_Out=32'h12345678, Frame_Err=0.
- Same scan with 2-cycle Seg glitch 8'hFF at each digit change → no false capture, result still 32'h12345678.
- Digit 3 driven Seg=8'hFF → Data_Out=32'h12340678, Frame_Err=1; next clean frame 32'hDEADBEEF clears Frame_Err.
- Sel held 8'h00 for TIMEOUT_CYC after 5 digits → Scan_Lost=1, no Data_Valid; restart full scan → Scan_Lost drops on first capture, full word correct.
- Sel=8'h03 (multi-hot) for 500 cycles inside a scan → ignored, mask unchanged.
- Reset pulse after 4 digits → outputs return to reset values; following full scan of 32'hA5A5A5A5 yields exactly one valid frame.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the 8-digit seven-segment scan driver.
// Deglitches the scanned Sel/Seg buses, decodes digits, rebuilds the 32-bit word.
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Sel,
    input  logic [7:0]  Seg,
    output logic [31:0] Data_Out,
    output logic        Data_Valid,
    output logic        Frame_Err,
    output logic        Scan_Lost
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYC);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] IDLE_HIT = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CAPT   = 2'd2;

    // sampled bus and the sample one cycle older
    logic [7:0]    s_sel;
    logic [7:0]    s_seg;
    logic [7:0]    p_sel;
    logic [7:0]    p_seg;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] idle;

    // per-digit nibble slots, error bits and capture mask
    logic [31:0]   slots;
    logic [7:0]    errs;
    logic [7:0]    mask;

    logic          changed;
    logic          onehot;
    logic [2:0]    idx;
    logic [3:0]    dec_nib;
    logic          dec_err;
    logic          cap;
    logic [31:0]   slots_nx;
    logic [7:0]    errs_nx;
    logic [7:0]    mask_nx;
    logic          done;

    // register the raw buses once, and keep the previous sample for change detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_sel <= 8'h00;
            s_seg <= 8'hFF;
            p_sel <= 8'h00;
            p_seg <= 8'hFF;
        end else begin
            s_sel <= Sel;
            s_seg <= Seg;
            p_sel <= s_sel;
            p_seg <= s_seg;
        end
    end

    // change / one-hot qualification of the sampled select
    always_comb begin
        changed = ({s_sel, s_seg} != {p_sel, p_seg});
        onehot  = (s_sel != 8'h00) && ((s_sel & (s_sel - 8'h01)) == 8'h00);
    end

    // one-hot select to digit index
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s_sel[i]) idx = 3'(i);
        end
    end

    // active-low segment pattern back to hex nibble; dp is ignored
    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (s_seg[6:0])
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_err = 1'b1;
            end
        endcase
    end

    // capture fires on the sample that brings the stable count to STABLE_CYC
    always_comb begin
        cap = (state == ST_SETTLE) && !changed && (cnt == CNT_LAST);
    end

    // slot contents as they would look after this cycle's capture
    always_comb begin
        slots_nx = slots;
        errs_nx  = errs;
        slots_nx[{idx, 2'b00} +: 4] = dec_nib;
        errs_nx[idx] = dec_err;
        mask_nx = mask | s_sel;
        done    = (mask_nx == 8'hFF);
    end

    // settle FSM: wait for one-hot, count identical samples, capture once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (onehot) begin
                        state <= ST_SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (changed) begin
                        if (onehot) begin
                            cnt   <= CW'(1);
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end
                    end else if (cap) begin
                        state <= ST_CAPT;
                        cnt   <= CNT_FULL;
                    end else begin
                        cnt   <= cnt + CW'(1);
                    end
                end
                ST_CAPT: begin
                    if (changed) begin
                        if (onehot) begin
                            state <= ST_SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // frame assembly, completion and scan-loss watchdog; capture beats timeout
    always_ff @(posedge Clk) begin
        if (Reset) begin
            slots      <= '0;
            errs       <= '0;
            mask       <= '0;
            idle       <= '0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            Frame_Err  <= 1'b0;
            Scan_Lost  <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            if (cap) begin
                slots     <= slots_nx;
                idle      <= '0;
                Scan_Lost <= 1'b0;
                if (done) begin
                    Data_Out   <= slots_nx;
                    Data_Valid <= 1'b1;
                    Frame_Err  <= |errs_nx;
                    mask       <= '0;
                    errs       <= '0;
                end else begin
                    mask <= mask_nx;
                    errs <= errs_nx;
                end
            end else if (idle != IDLE_MAX) begin
                idle <= idle + TW'(1);
                if (idle == IDLE_HIT) begin
                    Scan_Lost <= 1'b1;
                    mask      <= '0;
                    errs      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table of full-frame scans plus
// hand sequences for dwell boundaries, multi-hot, timeout and reset.
module tb_seg_scan_decoder;

    localparam int STB = 4;
    localparam int TO  = 500;
    localparam int DW  = 40;

    logic        Clk;
    logic        Reset;
    logic [7:0]  Sel;
    logic [7:0]  Seg;
    logic [31:0] Data_Out;
    logic        Data_Valid;
    logic        Frame_Err;
    logic        Scan_Lost;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int vcyc   = 0;
    int d_cyc  = 0;
    logic prev_dv = 1'b0;

    seg_scan_decoder #(
        .STABLE_CYC (STB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Sel       (Sel),
        .Seg       (Seg),
        .Data_Out  (Data_Out),
        .Data_Valid(Data_Valid),
        .Frame_Err (Frame_Err),
        .Scan_Lost (Scan_Lost)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // count valid pulses and flag back-to-back pulses
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Data_Valid) begin
                vcnt++;
                vcyc = cyc;
                chk("dv_no_back_to_back", 32'(prev_dv), 32'd0);
            end
            prev_dv = Data_Valid;
        end else begin
            prev_dv = 1'b0;
        end
    end

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return {1'b1, p};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic scan(input logic [31:0] w, input logic [7:0] bad,
                        input bit glitch, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            Sel = 8'(1 << i);
            if (glitch) begin
                Seg = 8'hFF;
                tick(2);
            end
            Seg = bad[i] ? 8'hFF : seg_of(w[i*4 +: 4]);
            d_cyc = cyc;
            tick(DW);
        end
    endtask

    typedef struct {
        logic [31:0] w;
        logic [7:0]  bad;
        bit          glitch;
        logic [31:0] exp;
        logic        exp_err;
    } row_t;

    row_t rows[7];
    int   v0;

    initial begin
        rows[0] = '{32'h12345678, 8'h00, 1'b0, 32'h12345678, 1'b0};
        rows[1] = '{32'h12345678, 8'h00, 1'b1, 32'h12345678, 1'b0};
        rows[2] = '{32'h12345678, 8'h08, 1'b0, 32'h12340678, 1'b1};
        rows[3] = '{32'hDEADBEEF, 8'h00, 1'b0, 32'hDEADBEEF, 1'b0};
        rows[4] = '{32'h01234567, 8'h00, 1'b1, 32'h01234567, 1'b0};
        rows[5] = '{32'h89ABCDEF, 8'h00, 1'b0, 32'h89ABCDEF, 1'b0};
        rows[6] = '{32'h89ABCDEF, 8'h81, 1'b0, 32'h09ABCDE0, 1'b1};

        Reset = 1'b1;
        Sel   = 8'h00;
        Seg   = 8'hFF;
        @(posedge Clk);
        #1;
        tick(3);
        chk("rst_data_out", Data_Out, 32'h0);
        chk("rst_valid", 32'(Data_Valid), 32'd0);
        chk("rst_frame_err", 32'(Frame_Err), 32'd0);
        chk("rst_scan_lost", 32'(Scan_Lost), 32'd0);
        Reset = 1'b0;
        tick(2);

        for (int r = 0; r < 7; r++) begin
            v0 = vcnt;
            scan(rows[r].w, rows[r].bad, rows[r].glitch, 0, 7);
            chk($sformatf("row%0d_valid_cnt", r), 32'(vcnt - v0), 32'd1);
            chk($sformatf("row%0d_data", r), Data_Out, rows[r].exp);
            chk($sformatf("row%0d_err", r), 32'(Frame_Err), 32'(rows[r].exp_err));
            chk($sformatf("row%0d_lost", r), 32'(Scan_Lost), 32'd0);
            chk($sformatf("row%0d_latency", r), 32'(vcyc - d_cyc), 32'(STB + 1));
        end

        // dwell one short of STABLE_CYC is ignored, exactly STABLE_CYC captures
        v0 = vcnt;
        scan(32'h13572468, 8'h00, 1'b0, 0, 6);
        Sel = 8'h80;
        Seg = seg_of(4'h1);
        tick(STB - 1);
        Sel = 8'h00;
        Seg = 8'hFF;
        tick(20);
        chk("short_dwell_no_valid", 32'(vcnt - v0), 32'd0);
        Sel = 8'h80;
        Seg = seg_of(4'h1);
        tick(STB);
        Sel = 8'h00;
        Seg = 8'hFF;
        tick(10);
        chk("exact_dwell_valid", 32'(vcnt - v0), 32'd1);
        chk("exact_dwell_data", Data_Out, 32'h13572468);

        // multi-hot select inside a scan is ignored
        v0 = vcnt;
        scan(32'h2468ACE0, 8'h00, 1'b0, 0, 3);
        Sel = 8'h03;
        Seg = seg_of(4'hE);
        tick(200);
        chk("multihot_no_valid", 32'(vcnt - v0), 32'd0);
        scan(32'h2468ACE0, 8'h00, 1'b0, 4, 7);
        chk("multihot_valid", 32'(vcnt - v0), 32'd1);
        chk("multihot_data", Data_Out, 32'h2468ACE0);

        // scan loss discards the partial frame but keeps Data_Out
        v0 = vcnt;
        scan(32'hCAFE1234, 8'h00, 1'b0, 0, 4);
        Sel = 8'h00;
        Seg = 8'hFF;
        tick(TO - 50);
        chk("pre_timeout_lost", 32'(Scan_Lost), 32'd0);
        tick(60);
        chk("timeout_lost", 32'(Scan_Lost), 32'd1);
        chk("timeout_no_valid", 32'(vcnt - v0), 32'd0);
        chk("timeout_data_kept", Data_Out, 32'h2468ACE0);
        scan(32'hCAFE1234, 8'h00, 1'b0, 5, 5);
        chk("lost_clears_on_capture", 32'(Scan_Lost), 32'd0);
        scan(32'hCAFE1234, 8'h00, 1'b0, 6, 7);
        chk("partial_discarded", 32'(vcnt - v0), 32'd0);
        scan(32'hCAFE1234, 8'h00, 1'b0, 0, 4);
        chk("restart_valid", 32'(vcnt - v0), 32'd1);
        chk("restart_data", Data_Out, 32'hCAFE1234);
        chk("restart_err", 32'(Frame_Err), 32'd0);

        // reset mid-frame wipes everything including the partial mask
        scan(32'h11223344, 8'h00, 1'b0, 0, 3);
        Reset = 1'b1;
        Sel   = 8'h00;
        Seg   = 8'hFF;
        tick(1);
        chk("midrst_data_out", Data_Out, 32'h0);
        chk("midrst_valid", 32'(Data_Valid), 32'd0);
        chk("midrst_frame_err", 32'(Frame_Err), 32'd0);
        chk("midrst_scan_lost", 32'(Scan_Lost), 32'd0);
        Reset = 1'b0;
        tick(2);
        v0 = vcnt;
        scan(32'hA5A5A5A5, 8'h00, 1'b0, 4, 7);
        chk("postrst_partial", 32'(vcnt - v0), 32'd0);
        scan(32'hA5A5A5A5, 8'h00, 1'b0, 0, 3);
        chk("postrst_valid", 32'(vcnt - v0), 32'd1);
        chk("postrst_data", Data_Out, 32'hA5A5A5A5);
        Sel = 8'h00;
        Seg = 8'hFF;
        tick(10);
        chk("postrst_single", 32'(vcnt - v0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
